control_unit_self_driving: RTL and testbench

Moore FSM that drives a self-driving car's speed controller and door lock. It compares the car speed against the speed limit and the leading-vehicle distance against a safety threshold, then selects Stop, Accelerate or Decelerate. It sits between the sensor and limit inputs and the drivetrain and door actuators. Both outputs decode from the state register only.

---
 rtl/control_unit_self_driving_pkg.sv | 16 +
 rtl/control_unit_self_driving.sv | 62 ++++++
 tb/tb_control_unit_self_driving.sv | 117 +++++++++++
 3 files changed

// File: rtl/control_unit_self_driving_pkg.sv
// Shared types and constants for the self-driving speed/door controller.
// Imported by the controller FSM.
package control_unit_self_driving_pkg;

   localparam int SPEED_W = 8;
   localparam int DIST_W  = 7;

   localparam logic [DIST_W-1:0] MIN_DISTANCE_DEF = 7'd40;

   typedef enum logic [1:0] {
      STOP       = 2'b00,
      ACCELERATE = 2'b01,
      DECELERATE = 2'b10
   } state_t;

endpackage

// File: rtl/control_unit_self_driving.sv
// Moore FSM choosing stop/accelerate/decelerate from speed and gap.
// Outputs are registered alongside the state so they never see input glitches.
module control_unit_self_driving
   import control_unit_self_driving_pkg::*;
#(
   parameter logic [DIST_W-1:0] MIN_DISTANCE = MIN_DISTANCE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SPEED_W-1:0] speed_limit,
   input  logic [SPEED_W-1:0] car_speed,
   input  logic [DIST_W-1:0]  leading_distance,
   output logic               unlock_doors,
   output logic               accelerate_car
);

   state_t state_q;
   state_t state_d;
   logic   unlock_q;
   logic   accel_q;

   logic safe;
   logic under_limit;
   logic stopped;
   logic go;

   assign safe        = (leading_distance >= MIN_DISTANCE);
   assign under_limit = (car_speed < speed_limit);
   assign stopped     = (car_speed == '0);
   assign go          = safe && under_limit;

   always_comb begin
      state_d = STOP;
      unique case (state_q)
         STOP:       state_d = go ? ACCELERATE : STOP;
         ACCELERATE: state_d = go ? ACCELERATE : DECELERATE;
         DECELERATE: begin
            // A halted car always parks, even if the road ahead is clear
            if (stopped)  state_d = STOP;
            else if (go)  state_d = ACCELERATE;
            else          state_d = DECELERATE;
         end
         default:    state_d = STOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= STOP;
         unlock_q <= 1'b1;
         accel_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         unlock_q <= (state_d != ACCELERATE) && (state_d != DECELERATE);
         accel_q  <= (state_d == ACCELERATE);
      end
   end

   assign unlock_doors   = unlock_q;
   assign accelerate_car = accel_q;

endmodule

// File: tb/tb_control_unit_self_driving.sv
// Directed plus randomized checks of the car controller against a
// behavioural model of the driving rules.
module tb_control_unit_self_driving;

   logic       clk;
   logic       rst;
   logic [7:0] speed_limit;
   logic [7:0] car_speed;
   logic [6:0] leading_distance;
   logic       unlock_doors;
   logic       accelerate_car;

   int errors = 0;
   int checks = 0;

   // model: "parked", "driving" (accelerating) or "braking"
   string mode;

   control_unit_self_driving dut (
      .clk              (clk),
      .rst              (rst),
      .speed_limit      (speed_limit),
      .car_speed        (car_speed),
      .leading_distance (leading_distance),
      .unlock_doors     (unlock_doors),
      .accelerate_car   (accelerate_car)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_edge();
      int  lim, spd, dst;
      bit  ok_to_go;
      lim = int'(speed_limit);
      spd = int'(car_speed);
      dst = int'(leading_distance);
      ok_to_go = (dst >= 40) && (spd < lim);
      if (rst) mode = "parked";
      else if (mode == "parked") begin
         if (ok_to_go) mode = "driving";
      end else if (mode == "driving") begin
         if (!ok_to_go) mode = "braking";
      end else begin
         if (spd == 0) mode = "parked";
         else if (ok_to_go) mode = "driving";
      end
   endtask

   task automatic step(input bit r, input int lim, input int spd,
                       input int dst, input string tag);
      bit exp_unlock, exp_accel;
      rst = r;
      speed_limit = 8'(lim);
      car_speed = 8'(spd);
      leading_distance = 7'(dst);
      @(posedge clk);
      model_edge();
      #1;
      exp_unlock = (mode == "parked");
      exp_accel  = (mode == "driving");
      checks++;
      assert (unlock_doors === exp_unlock) else begin
         errors++;
         $error("FAIL %s unlock_doors got %b want %b", tag, unlock_doors,
                exp_unlock);
      end
      checks++;
      assert (accelerate_car === exp_accel) else begin
         errors++;
         $error("FAIL %s accelerate_car got %b want %b", tag,
                accelerate_car, exp_accel);
      end
   endtask

   initial begin
      int lim, spd, dst;
      mode = "parked";
      rst = 1'b1;
      speed_limit = '0;
      car_speed = '0;
      leading_distance = '0;
      #2;
      step(1, 0, 0, 0, "reset1");
      step(1, 0, 0, 0, "reset2");
      step(0, 60, 0, 50, "start_acc");
      step(0, 60, 30, 30, "unsafe_dec");
      step(0, 60, 0, 30, "stopped_stop");
      step(0, 60, 0, 50, "re_acc");
      step(0, 60, 70, 50, "over_dec");
      step(0, 60, 30, 50, "dec_to_acc");
      step(0, 60, 0, 30, "acc_spd0_dec");
      step(0, 60, 0, 30, "dec_stop");
      step(0, 60, 0, 39, "dist39_hold");
      step(0, 60, 0, 40, "dist40_acc");
      step(0, 60, 0, 40, "acc_spd0_hold");
      step(0, 60, 60, 50, "equal_dec");
      step(0, 60, 30, 50, "back_acc");
      step(1, 60, 30, 50, "mid_reset");
      step(0, 60, 30, 50, "post_reset_acc");
      step(0, 60, 60, 50, "to_dec");
      step(0, 60, 0, 50, "prio_stop");
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 40 + i * 10, "limit0_hold");
      end
      for (int i = 0; i < 400; i++) begin
         lim = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 120);
         spd = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 120);
         if ($urandom_range(0, 5) == 0) spd = lim;
         dst = $urandom_range(30, 55);
         step($urandom_range(0, 24) == 0, lim, spd, dst, "random");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
